mem16x2_ctrl: RTL

Synthesizable 16-entry x 2-bit storage array with an address-indexed read port and a handshaked write port. It is the memory stage driven by the read-check stage: it receives that stage's 4-bit address and returns 2-bit data within one half clock period.
After reset, an internal fill sequencer loads a deterministic pattern so that read checks have known expected values. Writes are then accepted through a request/acknowledge handshake.

---
 rtl/mem16x2_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem16x2_ctrl.sv
// 16 x 2-bit storage array with a combinational read port, a post-reset
// fill sequencer that loads a known pattern, and a req/ack write port that
// commits one write every two cycles at most.
module mem16x2_ctrl #(
  parameter int            AW       = 4,
  parameter int            DW       = 2,
  parameter logic [DW-1:0] INIT_XOR = '0,
  parameter int            CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  output logic [DW-1:0]    data,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_ack,
  output logic             ready,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {FILL, IDLE, COMMIT} state_t;

  state_t            state_reg;
  logic [AW-1:0]     fill_ptr_reg;
  logic [AW-1:0]     cap_addr_reg;
  logic [DW-1:0]     cap_data_reg;
  logic              ready_reg;
  logic              wr_ack_reg;
  logic [CNT_W-1:0]  wr_count_reg;

  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     fill_rom [DEPTH];

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DW-1:0]     mem_wdata;

  // Constant fill pattern: entry i holds the low DW bits of i, XOR-masked.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fill_rom
      assign fill_rom[gi] = DW'(gi) ^ INIT_XOR;
    end
  endgenerate

  // Single write port shared by the fill sequencer and committed writes;
  // held off while reset is asserted so a pending commit never lands.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = fill_ptr_reg;
    mem_wdata = fill_rom[fill_ptr_reg];
    if (!rst) begin
      case (state_reg)
        FILL: begin
          mem_we = 1'b1;
        end
        COMMIT: begin
          mem_we    = 1'b1;
          mem_waddr = cap_addr_reg;
          mem_wdata = cap_data_reg;
        end
        default: begin
          mem_we = 1'b0;
        end
      endcase
    end
  end

  // Array storage: contents survive reset, the fill pass overwrites them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read is purely combinational; data is forced to zero until filled.
  assign data = ready_reg ? mem[addr] : '0;

  // Control FSM: fill pass, then request capture and one-cycle commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FILL;
      fill_ptr_reg <= '0;
      cap_addr_reg <= '0;
      cap_data_reg <= '0;
      ready_reg    <= 1'b0;
      wr_ack_reg   <= 1'b0;
      wr_count_reg <= '0;
    end else begin
      wr_ack_reg <= 1'b0;
      case (state_reg)
        FILL: begin
          fill_ptr_reg <= fill_ptr_reg + 1'b1;
          if (fill_ptr_reg == AW'(DEPTH - 1)) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
        IDLE: begin
          if (wr_req) begin
            cap_addr_reg <= wr_addr;
            cap_data_reg <= wr_data;
            state_reg    <= COMMIT;
          end
        end
        COMMIT: begin
          wr_ack_reg <= 1'b1;
          if (wr_count_reg != '1) begin
            wr_count_reg <= wr_count_reg + 1'b1;
          end
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign ready    = ready_reg;
  assign wr_ack   = wr_ack_reg;
  assign wr_count = wr_count_reg;

endmodule
